car_state_ctrl: RTL



---
 rtl/car_pkg.sv | 14 +
 rtl/car_state_ctrl_if.sv | 26 ++
 rtl/car_state_ctrl_btn_sync.sv | 21 ++
 rtl/car_state_ctrl.sv | 72 +++++++
 4 files changed

// File: rtl/car_pkg.sv
// Car driving-state encoding shared by the state controller, the manual-driving
// block and the display logic.
package car_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        POWER_OFF    = 2'b00,
        NOT_STARTING = 2'b01,
        STARTING     = 2'b10,
        MOVING       = 2'b11
    } car_state_e;

endpackage

// File: rtl/car_state_ctrl_if.sv
// Link between the car state controller (master) and the manual-driving block (slave).
interface car_state_ctrl_if;

    logic                        man_en;
    logic [car_pkg::STATE_W-1:0] man_cur;
    logic [car_pkg::STATE_W-1:0] state;
    logic                        power_led;
    logic                        hold_busy;

    modport master (
        input  man_en,
        input  man_cur,
        output state,
        output power_led,
        output hold_busy
    );

    modport slave (
        output man_en,
        output man_cur,
        input  state,
        input  power_led,
        input  hold_busy
    );

endinterface

// File: rtl/car_state_ctrl_btn_sync.sv
// Two-flop synchroniser bringing a raw board button into the clk domain.
module btn_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic sync
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= btn;
            sync <= meta;
        end
    end

endmodule

// File: rtl/car_state_ctrl.sv
// Sole owner of the car driving-state register: power-on hold, immediate
// power-off, and hand-off of state updates to the manual-driving block.
module car_state_ctrl
    import car_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 100_000_000,
    parameter int unsigned CNT_W       = 27
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    power_on_btn,
    input  logic                    power_off_btn,
    car_state_ctrl_if.master        man_if
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic             on_s;
    logic             off_s;
    car_state_e       state_q;
    car_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    btn_sync u_on_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (power_on_btn),
        .sync  (on_s)
    );

    btn_sync u_off_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (power_off_btn),
        .sync  (off_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= POWER_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter defaults to 0 so it only survives while a hold is in progress.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (off_s) begin
            state_d = POWER_OFF;
        end else if (state_q == POWER_OFF) begin
            if (on_s) begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = NOT_STARTING;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else if (man_if.man_en) begin
            state_d = car_state_e'(man_if.man_cur);
        end
    end

    assign man_if.state     = state_q;
    assign man_if.power_led = (state_q != POWER_OFF);
    assign man_if.hold_busy = (state_q == POWER_OFF) && on_s && (cnt_q != '0);

endmodule
